// File: rtl/uart_rx_frame_ctrl.sv
// Frame decoder behind a UART receiver: HDR, CMD, LEN, payload, XOR checksum.
// Delivers decoded frames over a valid/ready hold register and retunes bps_set on baud-select frames.
module uart_rx_frame_ctrl #(
    parameter int         TIMEOUT  = 50000,
    parameter logic [7:0] HDR      = 8'hA5,
    parameter logic [7:0] BAUD_CMD = 8'hB0,
    parameter logic [2:0] DEF_BPS  = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [2:0]  bps_set,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic [7:0]  frm_cmd,
    output logic [3:0]  frm_len,
    output logic [63:0] frm_data,
    output logic        frm_err,
    output logic [1:0]  err_code
);

    localparam int TW = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] E_OVR = 2'b00;
    localparam logic [1:0] E_CHK = 2'b01;
    localparam logic [1:0] E_LEN = 2'b10;
    localparam logic [1:0] E_TO  = 2'b11;

    typedef enum logic [2:0] {IDLE, CMD, LEN, DATA, CHK} state_t;

    state_t         state, state_nxt;
    logic           rx_done_q;
    logic           byte_ev;
    logic [7:0]     cmd_sh;
    logic [3:0]     len_sh;
    logic [63:0]    data_sh;
    logic [7:0]     csum;
    logic [3:0]     byte_cnt;
    logic [TW-1:0]  to_cnt;
    logic           timeout_hit;
    logic           frame_done;
    logic           deliver;
    logic           err_set;
    logic [1:0]     err_nxt;
    logic           baud_pend;
    logic [2:0]     baud_val;

    assign byte_ev     = rx_done & ~rx_done_q;
    assign timeout_hit = (state != IDLE) && (to_cnt == TO_MAX) && !byte_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        deliver    = 1'b0;
        err_set    = 1'b0;
        err_nxt    = E_OVR;
        if (byte_ev) begin
            case (state)
                IDLE: if (rx_data == HDR) state_nxt = CMD;
                CMD:  state_nxt = LEN;
                LEN: begin
                    if (rx_data > 8'd8) begin
                        err_set   = 1'b1;
                        err_nxt   = E_LEN;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = (rx_data == 8'd0) ? CHK : DATA;
                    end
                end
                DATA: if (byte_cnt == len_sh - 4'd1) state_nxt = CHK;
                CHK: begin
                    state_nxt = IDLE;
                    if (rx_data == csum) begin
                        frame_done = 1'b1;
                    end else begin
                        err_set = 1'b1;
                        err_nxt = E_CHK;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (timeout_hit) begin
            err_set   = 1'b1;
            err_nxt   = E_TO;
            state_nxt = IDLE;
        end
        // An accept in the same cycle frees the hold register, so only a stalled consumer overruns.
        if (frame_done) begin
            if (frm_valid && !frm_ready) begin
                err_set = 1'b1;
                err_nxt = E_OVR;
            end else begin
                deliver = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_q <= 1'b0;
            cmd_sh    <= 8'd0;
            len_sh    <= 4'd0;
            data_sh   <= 64'd0;
            csum      <= 8'd0;
            byte_cnt  <= 4'd0;
            to_cnt    <= '0;
        end else begin
            rx_done_q <= rx_done;
            if (state_nxt == IDLE || byte_ev) to_cnt <= '0;
            else if (to_cnt != '1)            to_cnt <= to_cnt + 1'b1;
            if (byte_ev) begin
                case (state)
                    CMD: begin
                        cmd_sh   <= rx_data;
                        csum     <= rx_data;
                        data_sh  <= 64'd0;
                        byte_cnt <= 4'd0;
                    end
                    LEN: begin
                        if (rx_data <= 8'd8) len_sh <= rx_data[3:0];
                        csum <= csum ^ rx_data;
                    end
                    DATA: begin
                        data_sh[{byte_cnt[2:0], 3'b000} +: 8] <= rx_data;
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_valid <= 1'b0;
            frm_cmd   <= 8'd0;
            frm_len   <= 4'd0;
            frm_data  <= 64'd0;
            frm_err   <= 1'b0;
            err_code  <= E_OVR;
            baud_pend <= 1'b0;
            baud_val  <= 3'd0;
            bps_set   <= DEF_BPS;
        end else begin
            frm_err <= err_set;
            if (err_set) err_code <= err_nxt;
            if (deliver) begin
                frm_valid <= 1'b1;
                frm_cmd   <= cmd_sh;
                frm_len   <= len_sh;
                frm_data  <= data_sh;
            end else if (frm_valid && frm_ready) begin
                frm_valid <= 1'b0;
            end
            // Baud change lands one cycle after the frame appears on the outputs.
            baud_pend <= deliver && (cmd_sh == BAUD_CMD) && (len_sh == 4'd1) &&
                         (data_sh[2:0] <= 3'd4);
            baud_val  <= data_sh[2:0];
            if (baud_pend) bps_set <= baud_val;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: byte sequences in, frame/error/baud behaviour checked.
module tb_uart_rx_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [2:0]  bps_set;
    logic        frm_valid;
    logic        frm_ready;
    logic [7:0]  frm_cmd;
    logic [3:0]  frm_len;
    logic [63:0] frm_data;
    logic        frm_err;
    logic [1:0]  err_code;

    int total = 0;
    int fails = 0;
    int cyc = 0;
    int err_cnt = 0;
    logic [1:0] last_code = 2'b00;
    int val_rise = 0;
    int val_cyc = 0;
    int bps_cyc = 0;
    logic prev_valid = 1'b0;
    logic [2:0] prev_bps = 3'd0;

    uart_rx_frame_ctrl #(.TIMEOUT(100)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .bps_set(bps_set), .frm_valid(frm_valid), .frm_ready(frm_ready),
        .frm_cmd(frm_cmd), .frm_len(frm_len), .frm_data(frm_data),
        .frm_err(frm_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event monitors, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rst_n && frm_err) begin
            err_cnt++;
            last_code = err_code;
        end
        if (frm_valid && !prev_valid) begin
            val_rise++;
            val_cyc = cyc;
        end
        if (bps_set != prev_bps) bps_cyc = cyc;
        prev_valid = frm_valid;
        prev_bps   = bps_set;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold = 1);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic accept();
        @(negedge clk);
        frm_ready = 1'b1;
        @(negedge clk);
        frm_ready = 1'b0;
    endtask

    initial begin
        int e0;
        int v0;
        int n;

        rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; frm_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", frm_valid, 0);
        chk("rst_err",   frm_err, 0);
        chk("rst_code",  err_code, 0);
        chk("rst_bps",   bps_set, 0);
        chk("rst_cmd",   frm_cmd, 0);
        chk("rst_len",   frm_len, 0);
        chk("rst_data",  frm_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good two-byte frame; XOR of 10,02,11,22 is 21.
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
        chk("f1_valid", frm_valid, 1);
        chk("f1_cmd",   frm_cmd, 8'h10);
        chk("f1_len",   frm_len, 2);
        chk("f1_data",  frm_data, 64'h2211);
        chk("f1_noerr", err_cnt, 0);
        repeat (5) @(negedge clk);
        chk("f1_hold",  frm_valid, 1);
        accept();
        chk("f1_drop",  frm_valid, 0);

        // Bad checksum.
        e0 = err_cnt; v0 = val_rise;
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h00);
        chk("chk_err",  err_cnt - e0, 1);
        chk("chk_code", last_code, 2'b01);
        chk("chk_nov",  val_rise - v0, 0);
        chk("chk_valid", frm_valid, 0);

        // Baud frame with out-of-range selector: delivered, bps untouched.
        v0 = val_rise;
        send(8'hA5); send(8'hB0); send(8'h01); send(8'h07); send(8'hB6);
        chk("b7_deliv", val_rise - v0, 1);
        chk("b7_data",  frm_data, 64'h07);
        chk("b7_bps",   bps_set, 0);
        accept();

        // Baud frame selecting 4.
        send(8'hA5); send(8'hB0); send(8'h01); send(8'h04); send(8'hB5);
        chk("b4_valid", frm_valid, 1);
        chk("b4_bps",   bps_set, 4);
        chk("b4_lat",   bps_cyc - val_cyc, 1);
        accept();

        // Length out of range, then an empty frame.
        e0 = err_cnt;
        send(8'hA5); send(8'h20); send(8'h09);
        chk("len_err",  err_cnt - e0, 1);
        chk("len_code", last_code, 2'b10);
        send(8'hA5); send(8'h20); send(8'h00); send(8'h20);
        chk("z_valid",  frm_valid, 1);
        chk("z_cmd",    frm_cmd, 8'h20);
        chk("z_len",    frm_len, 0);
        chk("z_data",   frm_data, 0);
        accept();

        // Timeout after CMD.
        e0 = err_cnt;
        send(8'hA5); send(8'h10);
        n = 0;
        while (err_cnt == e0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("to_err",   err_cnt - e0, 1);
        chk("to_code",  last_code, 2'b11);
        chk("to_late",  (n > 90) ? 1 : 0, 1);
        send(8'hA5); send(8'h30); send(8'h01); send(8'h5A); send(8'h6B);
        chk("to_next",  frm_valid, 1);
        chk("to_ncmd",  frm_cmd, 8'h30);
        chk("to_ndata", frm_data, 64'h5A);

        // Overrun: held frame stays put.
        e0 = err_cnt;
        send(8'hA5); send(8'h40); send(8'h01); send(8'h01); send(8'h40);
        chk("ov_err",   err_cnt - e0, 1);
        chk("ov_code",  last_code, 2'b00);
        chk("ov_cmd",   frm_cmd, 8'h30);
        chk("ov_valid", frm_valid, 1);

        // Checksum event coincides with accept of the held frame.
        e0 = err_cnt;
        send(8'hA5); send(8'h50); send(8'h01); send(8'h01);
        @(negedge clk);
        rx_data = 8'h50; rx_done = 1'b1; frm_ready = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; frm_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("acc_noerr", err_cnt - e0, 0);
        chk("acc_valid", frm_valid, 1);
        chk("acc_cmd",   frm_cmd, 8'h50);
        accept();

        // rx_done held 3 cycles per byte: one event per byte.
        send(8'hA5, 3); send(8'h60, 3); send(8'h01, 3); send(8'h77, 3); send(8'h16, 3);
        chk("hold_valid", frm_valid, 1);
        chk("hold_data",  frm_data, 64'h77);
        chk("hold_len",   frm_len, 1);
        accept();

        // Reset mid-frame: no error afterwards, next frame decodes.
        e0 = err_cnt;
        send(8'hA5); send(8'h10);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        chk("mr_noerr", err_cnt - e0, 0);
        chk("mr_bps",   bps_set, 0);
        send(8'hA5); send(8'h70); send(8'h00); send(8'h70);
        chk("mr_valid", frm_valid, 1);
        chk("mr_cmd",   frm_cmd, 8'h70);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
